// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS datapath: one control step per clock.
// Latency: FETCH/DECODE plus 1-3 execute steps; memory states stall on mem_ready.
// Backpressure: FETCH, MEMRD and MEMWR hold the request until mem_ready is seen.
module mc_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             iord,
  output logic             mem_re,
  output logic             mem_we,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ext_op,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JR     = 4'd12
  } state_t;

  // Opcodes and R-type function codes understood by the sequencer.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_LUI  = 3'd5;

  // State-decoded (Moore) control word, registered alongside the state.
  // pc_jmp is the unconditional PC write of JUMP/JR; the conditional
  // FETCH and BRANCH writes are formed from live inputs below.
  typedef struct packed {
    logic       iord;
    logic       mem_re;
    logic       mem_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ext_op;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       pc_jmp;
  } ctl_t;

  function automatic logic is_rt_alu(input logic [5:0] fn);
    return (fn == FN_ADDU) || (fn == FN_SUBU) || (fn == FN_AND) ||
           (fn == FN_OR)   || (fn == FN_SLT);
  endfunction

  function automatic logic [2:0] rt_alu_ctrl(input logic [5:0] fn);
    logic [2:0] a;
    case (fn)
      FN_SUBU: a = ALU_SUB;
      FN_AND:  a = ALU_AND;
      FN_OR:   a = ALU_OR;
      FN_SLT:  a = ALU_SLT;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    case (op)
      OP_RTYPE: ok = is_rt_alu(fn) || (fn == FN_JR);
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI, OP_LUI: ok = 1'b1;
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic [5:0] fn, input logic rdy);
    state_t n;
    case (s)
      S_FETCH:  n = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE: begin
            if (is_rt_alu(fn))     n = S_RTEXEC;
            else if (fn == FN_JR)  n = S_JR;
            else                   n = S_FETCH;
          end
          OP_LW, OP_SW:             n = S_MEMADR;
          OP_BEQ:                   n = S_BRANCH;
          OP_J:                     n = S_JUMP;
          OP_ADDI, OP_ORI, OP_LUI:  n = S_IEXEC;
          default:                  n = S_FETCH;
        endcase
      end
      S_MEMADR: n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  n = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  n = rdy ? S_FETCH : S_MEMWR;
      S_RTEXEC: n = S_RTWB;
      S_IEXEC:  n = S_IWB;
      default:  n = S_FETCH;
    endcase
    return n;
  endfunction

  // An instruction completes on each of these transitions back into FETCH.
  function automatic logic retires(input state_t s, input logic rdy);
    logic r;
    case (s)
      S_MEMWB, S_RTWB, S_BRANCH, S_JUMP, S_JR, S_IWB: r = 1'b1;
      S_MEMWR: r = rdy;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic ctl_t ctl_for(input state_t s, input logic [5:0] op,
                                   input logic [5:0] fn);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_re    = 1'b1;
        c.alu_src_b = 2'd1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'd3;
        c.ext_op    = 2'd1;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        c.ext_op    = 2'd1;
      end
      S_MEMRD: begin
        c.iord   = 1'b1;
        c.mem_re = 1'b1;
      end
      S_MEMWB: begin
        c.reg_we     = 1'b1;
        c.mem_to_reg = 2'd1;
      end
      S_MEMWR: begin
        c.iord   = 1'b1;
        c.mem_we = 1'b1;
      end
      S_RTEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_ctrl  = rt_alu_ctrl(fn);
      end
      S_RTWB: begin
        c.reg_we  = 1'b1;
        c.reg_dst = 2'd1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_ctrl  = ALU_SUB;
        c.pc_src    = 2'd1;
      end
      S_JUMP: begin
        c.pc_src = 2'd2;
        c.pc_jmp = 1'b1;
      end
      S_JR: begin
        c.pc_src = 2'd3;
        c.pc_jmp = 1'b1;
      end
      S_IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'd2;
        case (op)
          OP_ORI:  c.alu_ctrl = ALU_OR;
          OP_LUI:  c.alu_ctrl = ALU_LUI;
          default: begin
            c.ext_op   = 2'd1;
            c.alu_ctrl = ALU_ADD;
          end
        endcase
      end
      S_IWB: begin
        c.reg_we = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state_q;
  state_t state_nxt;
  ctl_t   ctl_q;

  assign state_nxt = next_state(state_q, opcode, funct, mem_ready);

  // Sequencer: state, its registered control word, illegal pulse and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      ctl_q      <= ctl_for(S_FETCH, opcode, funct);
      illegal    <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state_q    <= state_nxt;
      ctl_q      <= ctl_for(state_nxt, opcode, funct);
      illegal    <= (state_q == S_DECODE) && !is_supported(opcode, funct);
      if (retires(state_q, mem_ready)) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

  // PC/IR writes that depend on live inputs; suppressed while reset is held
  // so a reset never lets a fetch or branch commit.
  assign pc_we = !reset && (((state_q == S_FETCH) && mem_ready) ||
                            ((state_q == S_BRANCH) && zero) ||
                            ctl_q.pc_jmp);
  assign ir_we = !reset && (state_q == S_FETCH) && mem_ready;

  assign iord       = ctl_q.iord;
  assign mem_re     = ctl_q.mem_re;
  assign mem_we     = ctl_q.mem_we;
  assign reg_we     = ctl_q.reg_we;
  assign reg_dst    = ctl_q.reg_dst;
  assign mem_to_reg = ctl_q.mem_to_reg;
  assign alu_src_a  = ctl_q.alu_src_a;
  assign alu_src_b  = ctl_q.alu_src_b;
  assign ext_op     = ctl_q.ext_op;
  assign alu_ctrl   = ctl_q.alu_ctrl;
  assign pc_src     = ctl_q.pc_src;
  assign state      = state_q;

endmodule
